// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core constants and the fetch-stage state type.
package riscv_pkg;
    localparam int XLEN_DEFAULT = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    typedef enum logic [1:0] {BOOT, FETCH, HOLD, KILL} fetch_state_t;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: req/ack instruction-memory port.
interface fetch_stage_if #(parameter int XLEN = riscv_pkg::XLEN_DEFAULT);
    logic            imemReq;
    logic [XLEN-1:0] imemAddr;
    logic            imemAck;
    logic [31:0]     imemRdata;
    modport master (output imemReq, imemAddr, input imemAck, imemRdata);
    modport slave  (input imemReq, imemAddr, output imemAck, imemRdata);
endinterface

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register, flush over stall over load; empty loads become NOP bubbles.
module if_id_reg import riscv_pkg::*; #(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stallD,
    input  logic            flushD,
    input  logic            loadValid,
    input  logic [31:0]     instrIn,
    input  logic [XLEN-1:0] pcIn,
    output logic [31:0]     instrD,
    output logic [XLEN-1:0] pcD,
    output logic [XLEN-1:0] pcPlus4D,
    output logic            validD
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n || flushD) begin
            instrD   <= NOP_INSTR;
            pcD      <= '0;
            pcPlus4D <= '0;
            validD   <= 1'b0;
        end else if (!stallD) begin
            instrD   <= loadValid ? instrIn : NOP_INSTR;
            pcD      <= loadValid ? pcIn : '0;
            pcPlus4D <= loadValid ? pcIn + XLEN'(4) : '0;
            validD   <= loadValid;
        end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, fetch FSM, hold buffer and IF/ID register.
// FETCH_PERF_EN adds delivered-word and discarded-ack counters.
module fetch_stage import riscv_pkg::*; #(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stallF,
    input  logic            stallD,
    input  logic            flushD,
    input  logic            pcSrcE,
    input  logic [XLEN-1:0] pcTargetE,
    fetch_stage_if.master   imem,
    output logic            fetchStallF,
    output logic [31:0]     instrD,
    output logic [XLEN-1:0] pcD,
    output logic [XLEN-1:0] pcPlus4D,
    output logic            validD
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perfFetchCnt,
    output logic [31:0]     perfKillCnt
`endif
);
    fetch_state_t    state;
    logic [XLEN-1:0] pcF, killPc, holdPc;
    logic [31:0]     holdInstr;
    logic            ack, deliver, discard;

    assign ack           = imem.imemAck;
    assign imem.imemReq  = state == FETCH || state == KILL;
    assign imem.imemAddr = state == KILL ? killPc : pcF;
    assign fetchStallF   = (state == FETCH && !ack) || state == KILL;
    // A redirect or stall blocks delivery of both a fresh word and the buffered one.
    assign deliver       = !pcSrcE && !stallF && ((state == FETCH && ack) || state == HOLD);
    assign discard       = ack && ((state == FETCH && pcSrcE) || state == KILL);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= BOOT;
            pcF       <= RESET_PC;
            killPc    <= RESET_PC;
            holdPc    <= '0;
            holdInstr <= NOP_INSTR;
        end else
            case (state)
                BOOT: state <= FETCH;
                FETCH:
                    if (pcSrcE) begin
                        pcF <= pcTargetE;
                        if (!ack) begin
                            killPc <= pcF;
                            state  <= KILL;
                        end
                    end else if (ack && stallF) begin
                        holdInstr <= imem.imemRdata;
                        holdPc    <= pcF;
                        state     <= HOLD;
                    end else if (ack)
                        pcF <= pcF + XLEN'(4);
                HOLD:
                    if (pcSrcE) begin
                        pcF   <= pcTargetE;
                        state <= FETCH;
                    end else if (!stallF) begin
                        pcF   <= holdPc + XLEN'(4);
                        state <= FETCH;
                    end
                default: begin
                    if (pcSrcE) pcF <= pcTargetE;
                    if (ack) state <= FETCH;
                end
            endcase

    if_id_reg #(.XLEN(XLEN)) ifId (
        .clk      (clk),
        .rst_n    (rst_n),
        .stallD   (stallD),
        .flushD   (flushD),
        .loadValid(deliver),
        .instrIn  (state == HOLD ? holdInstr : imem.imemRdata),
        .pcIn     (state == HOLD ? holdPc : pcF),
        .instrD   (instrD),
        .pcD      (pcD),
        .pcPlus4D (pcPlus4D),
        .validD   (validD)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            perfFetchCnt <= '0;
            perfKillCnt  <= '0;
        end else begin
            perfFetchCnt <= perfFetchCnt + 32'(deliver);
            perfKillCnt  <= perfKillCnt + 32'(discard);
        end
`endif
endmodule
